// File: rtl/hello_scroll_ctrl.sv
// Scrolling "HELLO" controller for an 8-digit multiplexed 7-segment display.
// All outputs are registered from next-state values, so char_sel, an and
// digit_idx always describe the same digit in the same cycle.
module hello_scroll_ctrl #(
  parameter int unsigned REFRESH_DIV   = 1024,
  parameter int unsigned SCROLL_FRAMES = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       freeze,
  input  logic       dir,
  input  logic       load,
  output logic [2:0] char_sel,
  output logic [7:0] an,
  output logic [2:0] digit_idx,
  output logic       step_pulse
);

  localparam int unsigned REF_W   = 16;
  localparam int unsigned FRM_W   = 8;
  localparam int unsigned OFF_W   = 4;
  localparam int unsigned SUM_W   = 5;
  localparam int unsigned MSG_LEN = 13;

  typedef enum logic {
    ST_OFF = 1'b0,
    ST_RUN = 1'b1
  } state_t;

  state_t             r_state;
  logic [REF_W-1:0]   r_refresh;
  logic [FRM_W-1:0]   r_frame;
  logic [OFF_W-1:0]   r_offset;
  logic [2:0]         r_digit;
  logic [2:0]         r_char_sel;
  logic [7:0]         r_an;
  logic               r_step;

  state_t             w_state_nxt;
  logic               w_adv;
  logic               w_ref_tc;
  logic               w_dig_wrap;
  logic               w_frm_tc;
  logic               w_step;
  logic [REF_W-1:0]   w_refresh_nxt;
  logic [FRM_W-1:0]   w_frame_nxt;
  logic [OFF_W-1:0]   w_offset_nxt;
  logic [2:0]         w_digit_nxt;
  logic               w_pulse_nxt;
  logic [SUM_W-1:0]   w_sum;
  logic [SUM_W-1:0]   w_idx;
  logic [2:0]         w_code;
  logic [7:0]         w_an_nxt;
  logic [2:0]         w_char_nxt;

  // Next-state datapath: counters only advance while RUN persists with en high
  always_comb begin
    w_state_nxt   = en ? ST_RUN : ST_OFF;
    w_adv         = (r_state == ST_RUN) && en;
    w_ref_tc      = (r_refresh == REF_W'(REFRESH_DIV - 1));
    w_dig_wrap    = w_ref_tc && (r_digit == 3'd7);
    w_frm_tc      = (r_frame == FRM_W'(SCROLL_FRAMES - 1));
    w_step        = w_adv && w_dig_wrap && w_frm_tc;

    w_refresh_nxt = r_refresh;
    w_digit_nxt   = r_digit;
    w_frame_nxt   = r_frame;
    if (w_adv) begin
      w_refresh_nxt = w_ref_tc ? '0 : r_refresh + REF_W'(1);
      if (w_ref_tc) begin
        w_digit_nxt = r_digit + 3'd1;
      end
      if (w_dig_wrap) begin
        w_frame_nxt = w_frm_tc ? '0 : r_frame + FRM_W'(1);
      end
    end

    // Load wins over a coincident step; freeze suppresses only the offset move
    w_offset_nxt = r_offset;
    if (load) begin
      w_offset_nxt = '0;
    end else if (w_step && !freeze) begin
      if (dir) begin
        w_offset_nxt = (r_offset == '0) ? OFF_W'(MSG_LEN - 1) : r_offset - OFF_W'(1);
      end else begin
        w_offset_nxt = (r_offset == OFF_W'(MSG_LEN - 1)) ? '0 : r_offset + OFF_W'(1);
      end
    end
    w_pulse_nxt = load || (w_step && !freeze);

    // Circular message lookup: indices 0..4 spell HELLO, the rest are blank
    w_sum  = SUM_W'(w_offset_nxt) + SUM_W'(w_digit_nxt);
    w_idx  = (w_sum >= SUM_W'(MSG_LEN)) ? w_sum - SUM_W'(MSG_LEN) : w_sum;
    w_code = (w_idx < SUM_W'(5)) ? w_idx[2:0] : 3'd7;

    // Blank the whole display on refresh count 0 to hide digit-switch ghosting
    if ((w_state_nxt == ST_RUN) && (w_refresh_nxt != '0)) begin
      w_an_nxt = ~(8'h80 >> w_digit_nxt);
    end else begin
      w_an_nxt = 8'hFF;
    end
    w_char_nxt = (w_state_nxt == ST_RUN) ? w_code : 3'd7;
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_OFF;
      r_refresh  <= '0;
      r_frame    <= '0;
      r_offset   <= '0;
      r_digit    <= '0;
      r_char_sel <= 3'd7;
      r_an       <= 8'hFF;
      r_step     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_refresh  <= w_refresh_nxt;
      r_frame    <= w_frame_nxt;
      r_offset   <= w_offset_nxt;
      r_digit    <= w_digit_nxt;
      r_char_sel <= w_char_nxt;
      r_an       <= w_an_nxt;
      r_step     <= w_pulse_nxt;
    end
  end

  assign char_sel   = r_char_sel;
  assign an         = r_an;
  assign digit_idx  = r_digit;
  assign step_pulse = r_step;

endmodule

// File: tb/tb_hello_scroll_ctrl.sv
// Bench for hello_scroll_ctrl: directed scenarios followed by random stimulus,
// every cycle compared against a time-based reference model.
module tb_hello_scroll_ctrl;

  localparam int unsigned DIV = 4;
  localparam int unsigned FR  = 2;
  localparam int unsigned PER = 8 * DIV * FR;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       freeze = 1'b0;
  logic       dir = 1'b0;
  logic       load = 1'b0;
  logic [2:0] char_sel;
  logic [7:0] an;
  logic [2:0] digit_idx;
  logic       step_pulse;

  int n_checks = 0;
  int n_errors = 0;
  int pulse_cnt = 0;

  // Reference model: m_t counts enabled display cycles since reset; digit,
  // refresh phase and scroll boundaries are all derived from it arithmetically.
  int m_t = 0;
  int m_off = 0;
  bit m_run = 1'b0;
  bit m_pulse = 1'b0;
  int msg[13] = '{0, 1, 2, 3, 4, 7, 7, 7, 7, 7, 7, 7, 7};

  always #5 clk = ~clk;

  hello_scroll_ctrl #(
    .REFRESH_DIV  (DIV),
    .SCROLL_FRAMES(FR)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .freeze    (freeze),
    .dir       (dir),
    .load      (load),
    .char_sel  (char_sel),
    .an        (an),
    .digit_idx (digit_idx),
    .step_pulse(step_pulse)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, m_t, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_t = 0;
    m_off = 0;
    m_run = 1'b0;
    m_pulse = 1'b0;
  endfunction

  function automatic void model_edge();
    bit step;
    step = 1'b0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (m_run && en) begin
      m_t++;
      if (m_t % PER == 0) step = !freeze;
    end
    m_pulse = load || step;
    if (load) m_off = 0;
    else if (step) m_off = (m_off + (dir ? 12 : 1)) % 13;
    m_run = en;
  endfunction

  task automatic check_all();
    int dig;
    logic [7:0] exp_an;
    int exp_char;
    dig = (m_t / DIV) % 8;
    exp_an = 8'hFF;
    if (m_run && (m_t % DIV != 0)) exp_an[7 - dig] = 1'b0;
    exp_char = m_run ? msg[(m_off + dig) % 13] : 7;
    chk("digit_idx", 32'(digit_idx), 32'(dig));
    chk("an", 32'(an), 32'(exp_an));
    chk("char_sel", 32'(char_sel), 32'(exp_char));
    chk("step_pulse", 32'(step_pulse), 32'(m_pulse));
    if (step_pulse === 1'b1) pulse_cnt++;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  // Asynchronous reset asserted between clock edges must clear outputs at once
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    run(2);
    rst_n = 1'b1;
  endtask

  initial begin
    bit found;
    logic [2:0] held_digit;

    // Reset values
    run(3);
    rst_n = 1'b1;

    // Plain scanning from offset 0
    en = 1'b1;
    run(40);

    // Increment scrolling, wrapping 12 -> 0
    dir = 1'b0;
    run(PER * 14);

    // Decrement scrolling from offset 0 wraps to 12
    load = 1'b1;
    cyc();
    load = 1'b0;
    dir = 1'b1;
    run(PER * 3);

    // Freeze across two step boundaries: no pulses, scanning continues
    freeze = 1'b1;
    pulse_cnt = 0;
    run(PER * 2 + 10);
    chk("freeze_no_pulse", 32'(pulse_cnt), 32'd0);
    freeze = 1'b0;

    // Load coinciding with a scroll step at offset 5
    dir = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (m_off == 5 && m_run && ((m_t + 1) % PER == 0)) begin
        found = 1'b1;
        break;
      end
      cyc();
    end
    chk("load_align_found", 32'(found), 32'd1);
    load = 1'b1;
    cyc();
    load = 1'b0;
    chk("load_step_pulse", 32'(step_pulse), 32'd1);
    pulse_cnt = 0;
    run(10);
    chk("load_single_pulse", 32'(pulse_cnt), 32'd0);

    // Disable mid-digit, then resume from the held digit
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (m_t % DIV == 2) begin
        found = 1'b1;
        break;
      end
      cyc();
    end
    chk("mid_digit_found", 32'(found), 32'd1);
    held_digit = digit_idx;
    en = 1'b0;
    cyc();
    chk("off_an_blank", 32'(an), 32'hFF);
    load = 1'b1;
    cyc();
    load = 1'b0;
    run(3);
    en = 1'b1;
    cyc();
    chk("resume_digit", 32'(digit_idx), 32'(held_digit));
    run(20);

    // Asynchronous reset mid-frame
    async_reset();
    run(20);

    // Randomized operation
    for (int i = 0; i < 4000; i++) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0) freeze = ~freeze;
      dir = 1'($urandom_range(0, 1));
      load = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 799) == 0) async_reset();
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
